// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Holds the FSM state encoding, owner encoding and counter sizing helper.
package mem_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  typedef enum logic {
    OwnInstr = 1'b0,
    OwnData  = 1'b1
  } owner_e;

  localparam int unsigned StarveLimitDef = 3;
  localparam int unsigned TimeoutDef     = 63;

  // Bits needed to hold the values 0..max inclusive (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max);
    return (max < 2) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the instruction port, data port and cache-controller port.
// slave is the arbiter's view; master is the requesters' and cache's view.
interface mem_arbiter_if;

  logic        i_rd;
  logic [15:0] i_addr;
  logic        i_done;
  logic        i_stall;
  logic        i_err;
  logic [15:0] i_data_out;

  logic        d_rd;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_data_in;
  logic        d_done;
  logic        d_stall;
  logic        d_err;
  logic [15:0] d_data_out;

  logic        c_rd;
  logic        c_wr;
  logic [15:0] c_addr;
  logic [15:0] c_data_in;
  logic        c_done;
  logic        c_stall;
  logic [15:0] c_data_out;

  modport slave (
    input  i_rd, i_addr,
    output i_done, i_stall, i_err, i_data_out,
    input  d_rd, d_wr, d_addr, d_data_in,
    output d_done, d_stall, d_err, d_data_out,
    output c_rd, c_wr, c_addr, c_data_in,
    input  c_done, c_stall, c_data_out
  );

  modport master (
    output i_rd, i_addr,
    input  i_done, i_stall, i_err, i_data_out,
    output d_rd, d_wr, d_addr, d_data_in,
    input  d_done, d_stall, d_err, d_data_out,
    input  c_rd, c_wr, c_addr, c_data_in,
    output c_done, c_stall, c_data_out
  );

endinterface

// File: rtl/arb_counter.sv
// Up-counter saturating at Max with synchronous clear; clear beats increment.
module arb_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned Max   = 3,
  parameter int unsigned Width = cnt_width(Max)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);

  logic [Width-1:0] cnt_q;
  logic [Width-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MaxVal)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a single cache controller.
// Data is favoured until it starves a waiting instruction fetch STARVE_LIMIT times.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = StarveLimitDef,
  parameter int unsigned TIMEOUT      = TimeoutDef
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam int unsigned SW = cnt_width(STARVE_LIMIT);
  localparam int unsigned TW = cnt_width(TIMEOUT);

  state_e      state_q;
  owner_e      owner_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;

  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;

  logic idle, busy;
  logic d_illegal, d_valid, d_pref, can_grant;
  logic grant_i, grant_d;
  logic tmo_hit, fin_done, fin_err;

  // Every decision is qualified by rst so all outputs read 0 while reset is held.
  always_comb begin
    idle      = rst && (state_q == StIdle);
    busy      = rst && (state_q == StBusy);
    d_illegal = bus.d_rd & bus.d_wr;
    d_valid   = bus.d_rd ^ bus.d_wr;
    d_pref    = d_valid && (starve_cnt < SW'(STARVE_LIMIT));
    can_grant = idle && !bus.c_stall && !d_illegal;
    grant_d   = can_grant && (d_pref || (d_valid && !bus.i_rd));
    grant_i   = can_grant && bus.i_rd && !d_pref;
    tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
    fin_done  = busy && bus.c_done;
    fin_err   = busy && !bus.c_done && tmo_hit;
  end

  arb_counter #(
    .Max   (STARVE_LIMIT),
    .Width (SW)
  ) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (grant_i || (grant_d && !bus.i_rd)),
    .inc_i (grant_d && bus.i_rd),
    .cnt_o (starve_cnt)
  );

  arb_counter #(
    .Max   (TIMEOUT),
    .Width (TW)
  ) u_tmo_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (grant_i || grant_d),
    .inc_i (busy),
    .cnt_o (tmo_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      owner_q <= OwnData;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_i) begin
            state_q <= StBusy;
            owner_q <= OwnInstr;
            addr_q  <= bus.i_addr;
            wdata_q <= '0;
          end else if (grant_d) begin
            state_q <= StBusy;
            owner_q <= OwnData;
            addr_q  <= bus.d_addr;
            wdata_q <= bus.d_data_in;
          end
        end
        StBusy: begin
          if (fin_done || fin_err) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Cache-side request: a one-cycle strobe on grant, latched address/data while busy.
  always_comb begin
    bus.c_rd      = 1'b0;
    bus.c_wr      = 1'b0;
    bus.c_addr    = '0;
    bus.c_data_in = '0;
    if (grant_i) begin
      bus.c_rd   = 1'b1;
      bus.c_addr = bus.i_addr;
    end else if (grant_d) begin
      bus.c_rd      = bus.d_rd;
      bus.c_wr      = bus.d_wr;
      bus.c_addr    = bus.d_addr;
      bus.c_data_in = bus.d_data_in;
    end else if (busy) begin
      bus.c_addr    = addr_q;
      bus.c_data_in = wdata_q;
    end
  end

  always_comb begin
    bus.i_done     = fin_done && (owner_q == OwnInstr);
    bus.d_done     = fin_done && (owner_q == OwnData);
    bus.i_err      = fin_err && (owner_q == OwnInstr);
    bus.d_err      = (idle && d_illegal) || (fin_err && (owner_q == OwnData));
    bus.i_data_out = bus.i_done ? bus.c_data_out : '0;
    bus.d_data_out = bus.d_done ? bus.c_data_out : '0;
    bus.i_stall    = rst && bus.i_rd && !bus.i_done && !bus.i_err;
    bus.d_stall    = rst && (bus.d_rd || bus.d_wr) && !bus.d_done && !bus.d_err;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a reset-per-vector table of idle-cycle decisions,
// then hand-written sequences for completion, fairness, timeout and reset abort.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT (3),
    .TIMEOUT      (63)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        i_rd;
    logic [15:0] i_addr;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_din;
    logic        c_stall;
    logic        c_done;
    logic        e_crd;
    logic        e_cwr;
    logic [15:0] e_caddr;
    logic [15:0] e_cdin;
    logic        e_istall;
    logic        e_dstall;
    logic        e_derr;
    logic        e_idone;
    logic        e_ddone;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.i_rd       = 1'b0;
    bus.i_addr     = '0;
    bus.d_rd       = 1'b0;
    bus.d_wr       = 1'b0;
    bus.d_addr     = '0;
    bus.d_data_in  = '0;
    bus.c_done     = 1'b0;
    bus.c_stall    = 1'b0;
    bus.c_data_out = '0;
  endtask

  task automatic do_reset();
    next();
    clr_in();
    rst = 1'b0;
    next();
    rst = 1'b1;
  endtask

  initial begin
    string order;
    int    grants, since, early;
    logic  busy_m;

    vecs[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0,
                1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 16'h0040, 1'b1, 1'b0, 16'h0200, 16'h5555, 1'b0, 1'b0,
                1'b1, 1'b0, 16'h0200, 16'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0102, 16'hBEEF, 1'b0, 1'b0,
                1'b0, 1'b1, 16'h0102, 16'hBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16'h0040, 1'b1, 1'b1, 16'h0300, 16'h1111, 1'b0, 1'b0,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 16'h0040, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0300, 16'h0000, 1'b1, 1'b0,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1,
                1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 16'h0040, 1'b0, 1'b1, 16'h0500, 16'hABCD, 1'b0, 1'b1,
                1'b0, 1'b1, 16'h0500, 16'hABCD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    clr_in();

    // Held reset with a pending request: everything must stay quiet.
    next();
    bus.i_rd = 1'b1;
    bus.d_rd = 1'b1;
    @(negedge clk);
    chk("rst_c_rd", {31'b0, bus.c_rd}, 32'd0);
    chk("rst_i_stall", {31'b0, bus.i_stall}, 32'd0);
    chk("rst_d_stall", {31'b0, bus.d_stall}, 32'd0);

    // Table: each vector is applied in the first idle cycle after a fresh reset.
    for (int v = 0; v < 9; v++) begin
      do_reset();
      bus.i_rd       = vecs[v].i_rd;
      bus.i_addr     = vecs[v].i_addr;
      bus.d_rd       = vecs[v].d_rd;
      bus.d_wr       = vecs[v].d_wr;
      bus.d_addr     = vecs[v].d_addr;
      bus.d_data_in  = vecs[v].d_din;
      bus.c_stall    = vecs[v].c_stall;
      bus.c_done     = vecs[v].c_done;
      bus.c_data_out = 16'h9999;
      @(negedge clk);
      chk($sformatf("v%0d c_rd", v), {31'b0, bus.c_rd}, {31'b0, vecs[v].e_crd});
      chk($sformatf("v%0d c_wr", v), {31'b0, bus.c_wr}, {31'b0, vecs[v].e_cwr});
      chk($sformatf("v%0d c_addr", v), {16'b0, bus.c_addr}, {16'b0, vecs[v].e_caddr});
      chk($sformatf("v%0d c_data_in", v), {16'b0, bus.c_data_in}, {16'b0, vecs[v].e_cdin});
      chk($sformatf("v%0d i_stall", v), {31'b0, bus.i_stall}, {31'b0, vecs[v].e_istall});
      chk($sformatf("v%0d d_stall", v), {31'b0, bus.d_stall}, {31'b0, vecs[v].e_dstall});
      chk($sformatf("v%0d d_err", v), {31'b0, bus.d_err}, {31'b0, vecs[v].e_derr});
      chk($sformatf("v%0d i_done", v), {31'b0, bus.i_done}, {31'b0, vecs[v].e_idone});
      chk($sformatf("v%0d d_done", v), {31'b0, bus.d_done}, {31'b0, vecs[v].e_ddone});
      chk($sformatf("v%0d i_data_out", v), {16'b0, bus.i_data_out}, 32'd0);
      chk($sformatf("v%0d d_data_out", v), {16'b0, bus.d_data_out}, 32'd0);
    end

    // Instruction read, completion two cycles after grant.
    do_reset();
    bus.i_rd   = 1'b1;
    bus.i_addr = 16'h0040;
    @(negedge clk);
    chk("ird_grant_c_rd", {31'b0, bus.c_rd}, 32'd1);
    chk("ird_grant_addr", {16'b0, bus.c_addr}, 32'h0040);
    next();
    @(negedge clk);
    chk("ird_busy_c_rd", {31'b0, bus.c_rd}, 32'd0);
    chk("ird_busy_addr", {16'b0, bus.c_addr}, 32'h0040);
    chk("ird_busy_stall", {31'b0, bus.i_stall}, 32'd1);
    chk("ird_busy_done", {31'b0, bus.i_done}, 32'd0);
    next();
    bus.c_done     = 1'b1;
    bus.c_data_out = 16'h1234;
    @(negedge clk);
    chk("ird_done", {31'b0, bus.i_done}, 32'd1);
    chk("ird_data", {16'b0, bus.i_data_out}, 32'h1234);
    chk("ird_done_stall", {31'b0, bus.i_stall}, 32'd0);
    chk("ird_no_d_done", {31'b0, bus.d_done}, 32'd0);
    next();
    bus.c_done = 1'b0;
    bus.i_rd   = 1'b0;
    @(negedge clk);
    chk("ird_after_done", {31'b0, bus.i_done}, 32'd0);
    chk("ird_after_data", {16'b0, bus.i_data_out}, 32'd0);

    // Data write.
    do_reset();
    bus.d_wr      = 1'b1;
    bus.d_addr    = 16'h0102;
    bus.d_data_in = 16'hBEEF;
    @(negedge clk);
    chk("dwr_c_wr", {31'b0, bus.c_wr}, 32'd1);
    chk("dwr_c_addr", {16'b0, bus.c_addr}, 32'h0102);
    chk("dwr_c_din", {16'b0, bus.c_data_in}, 32'hBEEF);
    next();
    bus.d_data_in = 16'h0000;
    @(negedge clk);
    chk("dwr_busy_c_wr", {31'b0, bus.c_wr}, 32'd0);
    chk("dwr_busy_din", {16'b0, bus.c_data_in}, 32'hBEEF);
    next();
    bus.c_done     = 1'b1;
    bus.c_data_out = 16'h00AA;
    @(negedge clk);
    chk("dwr_d_done", {31'b0, bus.d_done}, 32'd1);
    chk("dwr_d_data", {16'b0, bus.d_data_out}, 32'h00AA);
    chk("dwr_i_done", {31'b0, bus.i_done}, 32'd0);

    // Illegal read+write, then a legal read on the following cycle.
    do_reset();
    bus.d_rd   = 1'b1;
    bus.d_wr   = 1'b1;
    bus.d_addr = 16'h0204;
    @(negedge clk);
    chk("ill_d_err", {31'b0, bus.d_err}, 32'd1);
    chk("ill_c_rdwr", {30'b0, bus.c_rd, bus.c_wr}, 32'd0);
    next();
    bus.d_wr = 1'b0;
    @(negedge clk);
    chk("ill_then_rd", {31'b0, bus.c_rd}, 32'd1);
    chk("ill_then_err", {31'b0, bus.d_err}, 32'd0);

    // Fairness: both requesters held, cache completes two cycles after each grant.
    do_reset();
    bus.i_rd   = 1'b1;
    bus.i_addr = 16'h0040;
    bus.d_rd   = 1'b1;
    bus.d_addr = 16'h0200;
    order  = "";
    grants = 0;
    since  = 0;
    busy_m = 1'b0;
    for (int c = 0; c < 60 && grants < 8; c++) begin
      if (c > 0) next();
      if (busy_m) since++;
      bus.c_done = busy_m && (since == 2);
      @(negedge clk);
      if (bus.c_done) busy_m = 1'b0;
      if (bus.c_rd) begin
        order  = {order, (bus.c_addr == 16'h0200) ? "D" : "I"};
        grants++;
        busy_m = 1'b1;
        since  = 0;
      end
    end
    chk("fair_grant_count", grants, 32'd8);
    chk("fair_order", {31'b0, order == "DDDIDDDI"}, 32'd1);
    if (order != "DDDIDDDI") $display("  order seen %s", order);

    // Timeout on a data read, then the same read completed on the last allowed cycle.
    do_reset();
    bus.d_rd   = 1'b1;
    bus.d_addr = 16'h0300;
    @(negedge clk);
    chk("tmo_grant", {31'b0, bus.c_rd}, 32'd1);
    early = 0;
    for (int k = 1; k <= 63; k++) begin
      next();
      @(negedge clk);
      if (k < 63) begin
        if (bus.d_err || bus.d_done || bus.c_rd) early++;
      end else begin
        chk("tmo_d_err", {31'b0, bus.d_err}, 32'd1);
        chk("tmo_d_done", {31'b0, bus.d_done}, 32'd0);
        chk("tmo_d_stall", {31'b0, bus.d_stall}, 32'd0);
      end
    end
    chk("tmo_no_early", early, 32'd0);
    next();
    @(negedge clk);
    chk("tmo_regrant", {31'b0, bus.c_rd}, 32'd1);
    early = 0;
    for (int k = 1; k <= 63; k++) begin
      next();
      bus.c_done     = (k == 63);
      bus.c_data_out = 16'h7777;
      @(negedge clk);
      if (k < 63) begin
        if (bus.d_err || bus.d_done) early++;
      end else begin
        chk("tmo_race_done", {31'b0, bus.d_done}, 32'd1);
        chk("tmo_race_err", {31'b0, bus.d_err}, 32'd0);
        chk("tmo_race_data", {16'b0, bus.d_data_out}, 32'h7777);
      end
    end
    chk("tmo_race_no_early", early, 32'd0);
    next();
    bus.c_done = 1'b0;

    // Reset two cycles into an instruction transaction.
    do_reset();
    bus.i_rd   = 1'b1;
    bus.i_addr = 16'h0040;
    @(negedge clk);
    chk("rab_grant", {31'b0, bus.c_rd}, 32'd1);
    next();
    next();
    rst        = 1'b0;
    bus.c_done = 1'b1;
    @(negedge clk);
    chk("rab_done", {31'b0, bus.i_done}, 32'd0);
    chk("rab_err", {31'b0, bus.i_err}, 32'd0);
    next();
    bus.c_done = 1'b0;
    @(negedge clk);
    chk("rab_outs", {bus.c_rd, bus.c_wr, bus.i_done, bus.i_err, bus.i_stall, bus.d_stall,
                     bus.d_done, bus.d_err, 8'h00, bus.c_addr}, 32'd0);
    chk("rab_cdin", {16'b0, bus.c_data_in}, 32'd0);
    next();
    rst = 1'b1;
    @(negedge clk);
    chk("rab_fresh_c_rd", {31'b0, bus.c_rd}, 32'd1);
    chk("rab_fresh_addr", {16'b0, bus.c_addr}, 32'h0040);
    next();
    next();
    bus.c_done     = 1'b1;
    bus.c_data_out = 16'h4321;
    @(negedge clk);
    chk("rab_fresh_done", {31'b0, bus.i_done}, 32'd1);
    chk("rab_fresh_data", {16'b0, bus.i_data_out}, 32'h4321);
    next();
    clr_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
